fdsync_shadow: RTL
==================

# fdsync_shadow

Parametrised bank of double-buffered load registers for TOM control state. Each channel has a shadow register written by the CPU-side load path and an active register driving the rest of the chip. Pending shadows move to their active registers together on a single commit strobe, for example line or frame start. An immediate-write mode bypasses the shadow. Generalises the 6-bit load-enable register with multi-channel addressing, atomic commit, pending tracking and a commit indicator.

## Interface
Parameters:
- WIDTH, 6, bits per channel (1..32)
- CHANNELS, 4, number of channels (1..16)
- RESET_VAL, 0, reset value of every shadow and active register (WIDTH bits)
- SELW, derived max(1, $clog2(CHANNELS)), select width (localparam)

Ports:
- sys_clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- ld  in  1  write d into the channel addressed by sel this cycle
- imm  in  1  qualifies ld: write shadow and active together, no pending
- sel  in  SELW  channel address for ld
- d  in  WIDTH  write data
- commit  in  1  copy every pending shadow to its active register
- q  out  CHANNELS*WIDTH  active registers; channel k at bits [k*WIDTH +: WIDTH]
- pending  out  CHANNELS  per-channel shadow-differs-from-last-commit flag
- committed  out  1  one-cycle pulse after a commit that transferred at least one channel

## Operation
- Reset value (reset high at an edge): every shadow and active register = RESET_VAL; pending = 0; committed = 0. Reset overrides ld, imm and commit in the same cycle.
- ld=1, imm=0, sel<CHANNELS: shadow[sel] <= d; pending[sel] <= 1; active unchanged.
- ld=1, imm=1, sel<CHANNELS: shadow[sel] <= d; active[sel] <= d; pending[sel] <= 0.
- ld=1, sel>=CHANNELS: write ignored; no state change from ld.
- imm without ld: no effect.
- commit=1: for every channel k whose effective pending is set, active[k] <= effective shadow[k] and pending[k] <= 0. Channels not pending keep their active value.
  - Effective values include a same-cycle ld. A write and a commit in the same cycle commit the new d.
- ld with imm=0 plus commit on the same channel: active[sel] <= d, shadow[sel] <= d, pending[sel] = 0.
- ld on channel a plus commit, with channel b pending: both a and b transfer in that cycle.
- Repeated ld to a pending channel before commit: last write wins; pending stays 1.
- committed <= commit AND (OR of effective pending, including a same-cycle non-imm ld). Otherwise committed <= 0.
- Writing a value equal to the current active still sets pending. No data comparison is performed.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- ld/imm to q: 1 cycle; q shows the new value in the cycle after the write edge.
- ld to pending: 1 cycle.
- commit to q and pending: 1 cycle; all channels change on the same edge (atomic).
- commit to committed: 1 cycle; committed is high for exactly one cycle per commit cycle.
- Back-to-back commits: the second transfers only channels written in between; committed pulses only if something transferred.
- Throughput: one write per cycle; commit accepted every cycle.
- Reset mid-operation: pending writes are discarded; q returns to RESET_VAL on the next cycle.

## Structure
- Shared TOM package: a function returning select width (max(1, clog2(n))) and the RESET_VAL default constant.
- Sub-module fdsync_shadow_chan:
  - holds one channel's shadow, active and pending registers;
  - inputs: wr, wr_imm, commit, d;
  - outputs: q, pending, xfer (effective pending AND commit).
- Top level:
  - decodes sel into per-channel wr;
  - generates CHANNELS instances;
  - ORs xfer into the committed register.

## Test plan
- Reset with WIDTH=6, CHANNELS=4, RESET_VAL=6'h2A:
  - q = 4×6'h2A, pending=0, committed=0.
  - Holds reset with ld=1, commit=1 asserted: still no change.
- ld sel=1 d=6'h15 imm=0:
  - next cycle pending=4'b0010, q ch1 unchanged.
  - commit one cycle later: ch1 = 6'h15, pending=0, committed pulses once.
- ld sel=2 d=6'h3F imm=1: next cycle q ch2 = 6'h3F, pending=0; a following commit gives committed=0.
- Write ch0=6'h01 (imm=0), then ld sel=3 d=6'h07 with commit in the same cycle:
  - next cycle ch0 = 6'h01, ch3 = 6'h07, pending=0, committed=1.
- CHANNELS=3, ld sel=3: no state change.
  - Then ld ch0 twice, 6'h0A then 6'h0B, and commit: ch0 = 6'h0B.
- Pending on ch1, then reset asserted for one cycle, then commit: ch1 = RESET_VAL, committed=0.

Source files
------------

// File: rtl/fdsync_shadow_pkg.sv
// Shared TOM definitions for the double-buffered load register bank.
package fdsync_shadow_pkg;

  localparam logic [31:0] RESET_VAL_DEFAULT = 32'h0;

  // A one-channel bank still needs a 1-bit select port.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fdsync_shadow_if.sv
// CPU-side load path plus active-register outputs of the shadow bank.
interface fdsync_shadow_if
  import fdsync_shadow_pkg::*;
#(
  parameter int WIDTH    = 6,
  parameter int CHANNELS = 4
);
  localparam int SELW = sel_w(CHANNELS);

  logic                      ld;
  logic                      imm;
  logic [SELW-1:0]           sel;
  logic [WIDTH-1:0]          d;
  logic                      commit;
  logic [CHANNELS*WIDTH-1:0] q;
  logic [CHANNELS-1:0]       pending;
  logic                      committed;

  modport master (output ld, imm, sel, d, commit, input q, pending, committed);
  modport slave  (input ld, imm, sel, d, commit, output q, pending, committed);
endinterface

// File: rtl/fdsync_shadow_chan.sv
// One channel: shadow, active and pending registers with same-cycle write/commit merge.
module fdsync_shadow_chan
  import fdsync_shadow_pkg::*;
#(
  parameter int               WIDTH     = 6,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VAL_DEFAULT)
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             wr_imm,
  input  logic             commit,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             pending,
  output logic             xfer
);
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] shadow_eff;
  logic             pend_eff;

  // A write in the commit cycle is what gets committed.
  assign shadow_eff = wr ? d : shadow;
  assign pend_eff   = wr ? !wr_imm : pending;
  assign xfer       = commit && pend_eff;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      shadow  <= RESET_VAL;
      q       <= RESET_VAL;
      pending <= 1'b0;
    end else begin
      if (wr) shadow <= d;
      if (wr && wr_imm) q <= d;
      else if (xfer)    q <= shadow_eff;
      pending <= pend_eff && !commit;
    end
  end
endmodule

// File: rtl/fdsync_shadow.sv
// Bank of double-buffered TOM load registers with atomic commit and commit pulse.
module fdsync_shadow
  import fdsync_shadow_pkg::*;
#(
  parameter int               WIDTH     = 6,
  parameter int               CHANNELS  = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VAL_DEFAULT)
) (
  input  logic          sys_clk,
  input  logic          reset,
  fdsync_shadow_if.slave bus
);
  localparam int SELW = sel_w(CHANNELS);

  logic [CHANNELS-1:0]            wr;
  logic [CHANNELS-1:0]            xfer;
  logic [CHANNELS-1:0]            pend;
  logic [CHANNELS-1:0][WIDTH-1:0] q_ch;
  logic                           committed;

  // Out-of-range selects match no channel, so the write is dropped.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    assign wr[k] = bus.ld && (bus.sel == SELW'(k));

    fdsync_shadow_chan #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_chan (
      .sys_clk (sys_clk),
      .reset   (reset),
      .wr      (wr[k]),
      .wr_imm  (bus.imm),
      .commit  (bus.commit),
      .d       (bus.d),
      .q       (q_ch[k]),
      .pending (pend[k]),
      .xfer    (xfer[k])
    );
  end

  always_ff @(posedge sys_clk) begin
    if (reset) committed <= 1'b0;
    else       committed <= |xfer;
  end

  assign bus.q         = q_ch;
  assign bus.pending   = pend;
  assign bus.committed = committed;
endmodule
